// File: rtl/debounce_pkg.sv
// debounce_pkg: shared state encoding and default timing for the button debouncer.
package debounce_pkg;
    typedef enum logic [1:0] {IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO} db_state_t;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: two-flop synchronizer plus stability FSM for one button bit.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_db,
    output logic btn_rise,
    output logic btn_fall
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic sync1, s;
    logic [CNT_W-1:0] cnt;
    db_state_t state;
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= 1'b0;
            s        <= 1'b0;
            state    <= IDLE_LO;
            cnt      <= '0;
            btn_db   <= 1'b0;
            btn_rise <= 1'b0;
            btn_fall <= 1'b0;
        end else begin
            sync1    <= btn_raw;
            s        <= sync1;
            btn_rise <= 1'b0;
            btn_fall <= 1'b0;
            case (state)
                IDLE_LO: if (s) begin
                    state <= WAIT_HI;
                    cnt   <= '0;
                end
                WAIT_HI: if (!s) begin
                    state <= IDLE_LO;
                    cnt   <= '0;
                end else if (cnt == LAST) begin
                    state    <= IDLE_HI;
                    btn_db   <= 1'b1;
                    btn_rise <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                IDLE_HI: if (!s) begin
                    state <= WAIT_LO;
                    cnt   <= '0;
                end
                WAIT_LO: if (s) begin
                    state <= IDLE_HI;
                    cnt   <= '0;
                end else if (cnt == LAST) begin
                    state    <= IDLE_LO;
                    btn_db   <= 1'b0;
                    btn_fall <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= IDLE_LO;
            endcase
        end
    end
endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: bank of independent debounce channels, one per push-button.
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_db,
    output logic [N_BTN-1:0] btn_rise,
    output logic [N_BTN-1:0] btn_fall
);
    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
            .clk     (clk),
            .reset   (reset),
            .btn_raw (btn_raw[i]),
            .btn_db  (btn_db[i]),
            .btn_rise(btn_rise[i]),
            .btn_fall(btn_fall[i])
        );
    end
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: scoreboard bench; a run-length reference model predicts each cycle's outputs.
module tb_button_debouncer;
    localparam int N = 2;
    localparam int D = 4;

    typedef struct packed {
        logic [N-1:0] db;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] btn_db, btn_rise, btn_fall;

    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;
    bit done = 1'b0;

    bit m_sync1[N], m_s[N], m_db[N];
    int m_run[N];

    button_debouncer #(.N_BTN(N), .DEBOUNCE_CYCLES(D)) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_raw),
        .btn_db  (btn_db),
        .btn_rise(btn_rise),
        .btn_fall(btn_fall)
    );

    always #5 clk = ~clk;

    // A level is accepted once D+1 consecutive synchronized samples disagree with it.
    task automatic cyc(input bit r, input logic [N-1:0] raw);
        exp_t e;
        @(negedge clk);
        reset = r;
        btn_raw = raw;
        e = '0;
        for (int c = 0; c < N; c++) begin
            if (r) begin
                m_sync1[c] = 0; m_s[c] = 0; m_db[c] = 0; m_run[c] = 0;
            end else begin
                bit seen;
                seen = m_s[c];
                m_s[c] = m_sync1[c];
                m_sync1[c] = raw[c];
                m_run[c] = (seen != m_db[c]) ? m_run[c] + 1 : 0;
                if (m_run[c] == D + 1) begin
                    m_db[c] = ~m_db[c];
                    m_run[c] = 0;
                    if (m_db[c]) e.rise[c] = 1'b1;
                    else e.fall[c] = 1'b1;
                end
            end
            e.db[c] = m_db[c];
        end
        q.push_back(e);
    endtask

    task automatic hold(input bit r, input logic [N-1:0] raw, input int n);
        for (int k = 0; k < n; k++) cyc(r, raw);
    endtask

    task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, got, want);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("btn_db", btn_db, e.db);
            check("btn_rise", btn_rise, e.rise);
            check("btn_fall", btn_fall, e.fall);
        end
    end

    initial begin
        logic [N-1:0] tgt, raw;
        hold(1, 2'b11, 3);
        hold(0, 2'b11, 10);
        hold(0, 2'b00, 10);
        hold(0, 2'b01, 10);
        hold(0, 2'b00, 10);
        hold(0, 2'b01, 3);
        hold(0, 2'b00, 1);
        hold(0, 2'b01, 10);
        hold(0, 2'b00, 10);
        cyc(0, 2'b11); cyc(0, 2'b10); cyc(0, 2'b01); cyc(0, 2'b11);
        cyc(0, 2'b01); cyc(0, 2'b11); cyc(0, 2'b10);
        hold(0, 2'b11, 12);
        hold(0, 2'b00, 10);
        hold(0, 2'b11, 5);
        hold(1, 2'b11, 1);
        hold(0, 2'b11, 10);
        tgt = '0;
        for (int k = 0; k < 1500; k++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 24) == 0) tgt[c] = ~tgt[c];
                raw[c] = ($urandom_range(0, 11) == 0) ? ~tgt[c] : tgt[c];
            end
            cyc($urandom_range(0, 299) == 0, raw);
        end
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
